// File: rtl/mem_copy_engine.sv
// mem_copy_engine: DMA-style word copier (read cycle then write cycle per word) over a single-port memory.
// Optional running sum of written words on `checksum` when MEM_COPY_CHECKSUM_EN is defined.
module mem_copy_engine #(
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] word_count,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] xfer_count,
`ifdef MEM_COPY_CHECKSUM_EN
  output logic [31:0]      checksum,
`endif
  output logic             mem_write,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] src_ptr, dst_ptr, data_buf;
  logic [LEN_W-1:0] rem;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !start ? IDLE : (word_count == '0 ? DONE : READ);
      READ:    state_nx = abort ? DONE : WRITE;
      WRITE:   state_nx = (abort || rem == LEN_W'(1)) ? DONE : READ;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      src_ptr    <= '0;
      dst_ptr    <= '0;
      data_buf   <= '0;
      rem        <= '0;
      xfer_count <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else if (state == IDLE && start) begin
      src_ptr    <= src_addr & ~32'h3;
      dst_ptr    <= dst_addr & ~32'h3;
      rem        <= word_count;
      xfer_count <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else if (state == READ && !abort) begin
      data_buf <= mem_read_data;
      src_ptr  <= src_ptr + 32'd4;
    end else if (state == WRITE) begin
      dst_ptr    <= dst_ptr + 32'd4;
      rem        <= rem - LEN_W'(1);
      xfer_count <= xfer_count + LEN_W'(1);
`ifdef MEM_COPY_CHECKSUM_EN
      checksum   <= checksum + data_buf;
`endif
    end
  // Address parks on dst_ptr outside READ so the bus does not toggle while idle.
  assign mem_address    = state == READ ? src_ptr : dst_ptr;
  assign mem_write_data = data_buf;
  assign mem_write      = state == WRITE;
  assign busy           = state == READ || state == WRITE;
  assign done           = state == DONE;
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed checks of mem_copy_engine against a behavioural word memory.
module tb_mem_copy_engine;
  logic clk = 0, reset_n = 0, start = 0, abort = 0;
  logic [31:0] src_addr = 0, dst_addr = 0;
  logic [9:0] word_count = 0, xfer_count;
  logic busy, done, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  logic [31:0] mem [1024];
  logic [31:0] waddr [64];
  logic [31:0] raddr [64];
  int nw = 0, nr, errors = 0, checks = 0, cyc, busy_seen, abort_cyc, restart_cyc, w0;

  mem_copy_engine #(.LEN_W(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .word_count(word_count), .abort(abort), .busy(busy), .done(done), .xfer_count(xfer_count),
`ifdef MEM_COPY_CHECKSUM_EN
    .checksum(checksum),
`endif
    .mem_write(mem_write), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;
  assign mem_read_data = mem[mem_address[11:2]];
  always @(posedge clk)
    if (mem_write) begin
      mem[mem_address[11:2]] <= mem_write_data;
      waddr[nw[5:0]] <= mem_address;
      nw <= nw + 1;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [9:0] n);
    src_addr = s; dst_addr = d; word_count = n; start = 1;
  endtask

  // Runs until done (bounded); abort/restart injected at the given negedge index.
  task automatic wait_done();
    cyc = 0; busy_seen = 0; nr = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = 0; abort = 0;
      if (busy) busy_seen = 1;
      if (busy && !mem_write) begin raddr[nr[5:0]] = mem_address; nr++; end
      if (cyc == abort_cyc) abort = 1;
      if (cyc == restart_cyc) go(32'h0, 32'h600, 10'd5);
    end while (!done && cyc < 60);
    start = 0; abort = 0; abort_cyc = -1; restart_cyc = -1;
  endtask

  initial begin
    abort_cyc = -1; restart_cyc = -1;
    for (int i = 0; i < 1024; i++) mem[i] = 0;
    mem[0] = 11; mem[1] = 22; mem[2] = 33; mem[3] = 44; mem[4] = 55;
    #12;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_wr", {31'b0, mem_write}, 0);
    chk("rst_xfer", {22'b0, xfer_count}, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_write_data, 0);
    @(negedge clk); reset_n = 1;
    @(negedge clk);
    // basic copy
    w0 = nw; go(32'h0, 32'h100, 10'd4); wait_done();
    chk("cp_cycles", cyc, 9);
    chk("cp_writes", nw - w0, 4);
    chk("cp_m0", mem[16'h40], 11);
    chk("cp_m1", mem[16'h41], 22);
    chk("cp_m2", mem[16'h42], 33);
    chk("cp_m3", mem[16'h43], 44);
    chk("cp_xfer", {22'b0, xfer_count}, 4);
    chk("cp_busy_done", {31'b0, busy}, 0);
    chk("cp_done_addr", mem_address, 32'h110);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("cp_csum", checksum, 32'h6E);
`endif
    @(negedge clk);
    chk("cp_done_pulse", {31'b0, done}, 0);
    // zero length
    w0 = nw; go(32'h0, 32'h100, 10'd0); wait_done();
    chk("z_cycles", cyc, 1);
    chk("z_writes", nw - w0, 0);
    chk("z_busy", busy_seen, 0);
    chk("z_xfer", {22'b0, xfer_count}, 0);
    @(negedge clk);
    // misaligned source, destination wrapping past 2^32
    w0 = nw; go(32'h3, 32'hFFFFFFFC, 10'd2); wait_done();
    chk("w_cycles", cyc, 5);
    chk("w_rd0", raddr[0], 32'h0);
    chk("w_rd1", raddr[1], 32'h4);
    chk("w_wr0", waddr[w0[5:0]], 32'hFFFFFFFC);
    chk("w_wr1", waddr[(w0 + 1) % 64], 32'h0);
    chk("w_m3ff", mem[1023], 11);
    chk("w_m0", mem[0], 22);
    @(negedge clk);
    // abort during WRITE of word 3 (mem[0..2] = 22,22,33 now)
    w0 = nw; abort_cyc = 6; go(32'h0, 32'h200, 10'd8); wait_done();
    chk("aw_cycles", cyc, 7);
    chk("aw_writes", nw - w0, 3);
    chk("aw_xfer", {22'b0, xfer_count}, 3);
    chk("aw_m2", mem[16'h82], 33);
    chk("aw_m3", mem[16'h83], 0);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("aw_csum", checksum, 77);
`endif
    @(negedge clk);
    // abort during READ of word 2
    w0 = nw; abort_cyc = 3; go(32'h0, 32'h300, 10'd4); wait_done();
    chk("ar_cycles", cyc, 4);
    chk("ar_writes", nw - w0, 1);
    chk("ar_xfer", {22'b0, xfer_count}, 1);
    chk("ar_m1", mem[16'hC1], 0);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("ar_csum", checksum, 22);
`endif
    @(negedge clk);
    // asynchronous reset in WRITE
    w0 = nw; go(32'h0, 32'h700, 10'd4);
    @(negedge clk); start = 0;
    @(negedge clk);
    chk("rw_in_write", {31'b0, mem_write}, 1);
    #1 reset_n = 0;
    #1;
    chk("rw_wr", {31'b0, mem_write}, 0);
    chk("rw_busy", {31'b0, busy}, 0);
    chk("rw_xfer", {22'b0, xfer_count}, 0);
    @(negedge clk);
    chk("rw_writes", nw - w0, 0);
    reset_n = 1;
    @(negedge clk);
    go(32'h10, 32'h400, 10'd1); wait_done();
    chk("rw_cycles", cyc, 3);
    chk("rw_m", mem[16'h100], 55);
    chk("rw_xfer2", {22'b0, xfer_count}, 1);
    @(negedge clk);
    // start pulsed while busy is ignored
    w0 = nw; restart_cyc = 2; go(32'h8, 32'h500, 10'd2); wait_done();
    chk("sb_cycles", cyc, 5);
    chk("sb_writes", nw - w0, 2);
    chk("sb_m0", mem[16'h140], 33);
    chk("sb_m1", mem[16'h141], 44);
    chk("sb_other", mem[16'h180], 0);
    chk("sb_xfer", {22'b0, xfer_count}, 2);
    @(negedge clk);
    chk("sb_idle", {30'b0, busy, done}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
